// File: rtl/pipe_pkg.sv
// Shared opcode constants and controller state encoding for the pipeline
// hazard controller.
package pipe_pkg;

   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_SW  = 4'b1001;
   localparam logic [3:0] OP_B   = 4'b1010;
   localparam logic [3:0] OP_BR  = 4'b1011;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [1:0] DRAIN_LEN = 2'd2;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised event counter that sticks at all-ones instead of
// wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);
   localparam logic [W-1:0] MAX = {W{1'b1}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != MAX)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: load-use stalls, branch flushes,
// data-memory freezes and HLT drain, plus saturating stall/flush counters.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_op,
   input  logic [3:0]       id_rs,
   input  logic [3:0]       id_rt,
   input  logic [3:0]       ex_op,
   input  logic [3:0]       ex_rd,
   input  logic             ex_br_taken,
   input  logic             dmem_busy,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             if_id_clr,
   output logic             id_ex_clr,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_t     state, state_nxt;
   state_t     eff_state;
   logic       ret_drain, ret_drain_nxt;
   logic [1:0] drain_cnt, drain_cnt_nxt;
   logic       stall_inc, flush_inc;
   logic       load_use;
   logic       unused_ok;

   // The ID opcode is not needed for hazard detection; operands are compared
   // unconditionally, which is conservative for instructions lacking rt.
   assign unused_ok = ^{id_op, OP_SW, OP_B, OP_BR};

   assign load_use = (ex_op == OP_LW) && (ex_rd != 4'd0) &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         ret_drain <= 1'b0;
         drain_cnt <= 2'd0;
      end else begin
         state     <= state_nxt;
         ret_drain <= ret_drain_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   // MEM_WAIT behaves as whichever state it interrupted once memory is ready.
   always_comb begin
      eff_state = state;
      if (state == MEM_WAIT) begin
         eff_state = ret_drain ? DRAIN : RUN;
      end
   end

   always_comb begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_we     = 1'b0;
      if_id_clr     = 1'b0;
      id_ex_clr     = 1'b0;
      halted        = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      state_nxt     = state;
      ret_drain_nxt = ret_drain;
      drain_cnt_nxt = drain_cnt;

      if (rst) begin
         if (state == HALTED) begin
            halted = 1'b1;
         end else if (dmem_busy) begin
            stall_inc     = 1'b1;
            state_nxt     = MEM_WAIT;
            ret_drain_nxt = (eff_state == DRAIN);
         end else if (eff_state == DRAIN) begin
            id_ex_we      = 1'b1;
            ex_mem_we     = 1'b1;
            mem_wb_we     = 1'b1;
            id_ex_clr     = 1'b1;
            drain_cnt_nxt = (drain_cnt == 2'd0) ? 2'd0 : drain_cnt - 2'd1;
            state_nxt     = (drain_cnt <= 2'd1) ? HALTED : DRAIN;
         end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
            state_nxt = RUN;
            // Lower-priority events are simply not acted on; the held pipeline
            // registers present them again next cycle.
            if (ex_br_taken) begin
               if_id_clr = 1'b1;
               id_ex_clr = 1'b1;
               flush_inc = 1'b1;
            end else if (ex_op == OP_HLT) begin
               pc_we         = 1'b0;
               if_id_we      = 1'b0;
               id_ex_clr     = 1'b1;
               state_nxt     = DRAIN;
               drain_cnt_nxt = DRAIN_LEN;
            end else if (load_use) begin
               pc_we     = 1'b0;
               if_id_we  = 1'b0;
               id_ex_clr = 1'b1;
               stall_inc = 1'b1;
            end
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush_inc),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; a second instance with 4-bit
// counters shares the stimulus to exercise counter saturation.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  id_op, id_rs, id_rt, ex_op, ex_rd;
   logic        ex_br_taken, dmem_busy;

   logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
   logic        if_id_clr, id_ex_clr, halted;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_we, s_if_id_we, s_id_ex_we, s_ex_mem_we, s_mem_wb_we;
   logic        s_if_id_clr, s_id_ex_clr, s_halted;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   logic [7:0]  obs;

   int checks   = 0;
   int failures = 0;

   // {pc, if_id, id_ex, ex_mem, mem_wb}_we, {if_id, id_ex}_clr, halted
   localparam logic [7:0] V_RESET  = 8'b00000_00_0;
   localparam logic [7:0] V_RUN    = 8'b11111_00_0;
   localparam logic [7:0] V_STALL  = 8'b00111_01_0;
   localparam logic [7:0] V_FLUSH  = 8'b11111_11_0;
   localparam logic [7:0] V_FREEZE = 8'b00000_00_0;
   localparam logic [7:0] V_HALT   = 8'b00000_00_1;

   localparam logic [3:0] LW  = 4'b1000;
   localparam logic [3:0] HLT = 4'b1111;
   localparam logic [3:0] NOP = 4'b0000;

   assign obs = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                 if_id_clr, id_ex_clr, halted};

   pipe_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .id_op       (id_op),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .ex_op       (ex_op),
      .ex_rd       (ex_rd),
      .ex_br_taken (ex_br_taken),
      .dmem_busy   (dmem_busy),
      .pc_we       (pc_we),
      .if_id_we    (if_id_we),
      .id_ex_we    (id_ex_we),
      .ex_mem_we   (ex_mem_we),
      .mem_wb_we   (mem_wb_we),
      .if_id_clr   (if_id_clr),
      .id_ex_clr   (id_ex_clr),
      .halted      (halted),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
   );

   pipe_ctrl #(.CNT_W(4)) dut_sat (
      .clk         (clk),
      .rst         (rst),
      .id_op       (id_op),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .ex_op       (ex_op),
      .ex_rd       (ex_rd),
      .ex_br_taken (ex_br_taken),
      .dmem_busy   (dmem_busy),
      .pc_we       (s_pc_we),
      .if_id_we    (s_if_id_we),
      .id_ex_we    (s_id_ex_we),
      .ex_mem_we   (s_ex_mem_we),
      .mem_wb_we   (s_mem_wb_we),
      .if_id_clr   (s_if_id_clr),
      .id_ex_clr   (s_id_ex_clr),
      .halted      (s_halted),
      .stall_cnt   (s_stall_cnt),
      .flush_cnt   (s_flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drives one cycle's inputs shortly after the rising edge, then lets the
   // combinational outputs settle before any check.
   task automatic applyStimulus(input logic [3:0] eop, input logic [3:0] erd,
                                input logic [3:0] irs, input logic [3:0] irt,
                                input logic br, input logic busy);
      id_op       = NOP;
      ex_op       = eop;
      ex_rd       = erd;
      id_rs       = irs;
      id_rt       = irt;
      ex_br_taken = br;
      dmem_busy   = busy;
      #2;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      rst = 1'b0;
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      stepClock();
      stepClock();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      stepClock();
      checkOutput("reset_outs", 32'(obs), 32'(V_RESET));
      checkOutput("reset_stall", 32'(stall_cnt), 32'd0);
      checkOutput("reset_flush", 32'(flush_cnt), 32'd0);
      stepClock();
      rst = 1'b1;
      #1;
      checkOutput("post_reset_run", 32'(obs), 32'(V_RUN));
      stepClock();

      // Load-use on rs, then a zero-register non-hazard, then load-use on rt
      applyStimulus(LW, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0);
      checkOutput("lu_rs_outs", 32'(obs), 32'(V_STALL));
      stepClock();
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("lu_rs_stall", 32'(stall_cnt), 32'd1);
      checkOutput("after_lu_run", 32'(obs), 32'(V_RUN));
      applyStimulus(LW, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("lu_r0_outs", 32'(obs), 32'(V_RUN));
      stepClock();
      checkOutput("lu_r0_stall", 32'(stall_cnt), 32'd1);
      applyStimulus(LW, 4'd5, 4'd1, 4'd5, 1'b0, 1'b0);
      checkOutput("lu_rt_outs", 32'(obs), 32'(V_STALL));
      stepClock();
      checkOutput("lu_rt_stall", 32'(stall_cnt), 32'd2);

      // Branch beats a simultaneous load-use
      applyStimulus(LW, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0);
      checkOutput("br_lu_outs", 32'(obs), 32'(V_FLUSH));
      stepClock();
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("br_flush", 32'(flush_cnt), 32'd1);
      checkOutput("br_stall", 32'(stall_cnt), 32'd2);

      // Four busy cycles, one with a masked branch
      for (int i = 0; i < 4; i++) begin
         applyStimulus(NOP, 4'd0, 4'd0, 4'd0, (i == 2), 1'b1);
         checkOutput($sformatf("busy_outs_%0d", i), 32'(obs), 32'(V_FREEZE));
         stepClock();
      end
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("busy_resume", 32'(obs), 32'(V_RUN));
      checkOutput("busy_stall", 32'(stall_cnt), 32'd6);
      checkOutput("busy_flush", 32'(flush_cnt), 32'd1);
      stepClock();

      // Load-use masked by busy is honoured the following cycle
      applyStimulus(LW, 4'd3, 4'd3, 4'd0, 1'b0, 1'b1);
      checkOutput("mask_busy_outs", 32'(obs), 32'(V_FREEZE));
      stepClock();
      checkOutput("mask_busy_stall", 32'(stall_cnt), 32'd7);
      applyStimulus(LW, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0);
      checkOutput("mask_reeval_outs", 32'(obs), 32'(V_STALL));
      stepClock();
      checkOutput("mask_reeval_stall", 32'(stall_cnt), 32'd8);

      // Reset asserted while waiting on memory
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
      stepClock();
      rst = 1'b0;
      #1;
      checkOutput("rst_memwait_outs", 32'(obs), 32'(V_RESET));
      checkOutput("rst_memwait_stall", 32'(stall_cnt), 32'd0);
      checkOutput("rst_memwait_flush", 32'(flush_cnt), 32'd0);
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      stepClock();
      rst = 1'b1;
      #1;
      checkOutput("rst_release_run", 32'(obs), 32'(V_RUN));
      stepClock();
      checkOutput("rst_release_run2", 32'(obs), 32'(V_RUN));

      // HLT, two drain cycles with one busy cycle in between, then halted
      applyStimulus(HLT, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("hlt_detect", 32'(obs), 32'(V_STALL));
      stepClock();
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("drain_1", 32'(obs), 32'(V_STALL));
      stepClock();
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
      checkOutput("drain_busy", 32'(obs), 32'(V_FREEZE));
      stepClock();
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("drain_2", 32'(obs), 32'(V_STALL));
      stepClock();
      checkOutput("halted_1", 32'(obs), 32'(V_HALT));
      stepClock();
      applyStimulus(LW, 4'd3, 4'd3, 4'd0, 1'b1, 1'b1);
      checkOutput("halted_sticky", 32'(obs), 32'(V_HALT));
      stepClock();
      checkOutput("halted_stall", 32'(stall_cnt), 32'd1);
      checkOutput("halted_flush", 32'(flush_cnt), 32'd0);

      // Twenty load-use cycles: 16-bit counter reaches 20, 4-bit sticks at 15
      resetDut();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(LW, 4'd7, 4'd0, 4'd7, 1'b0, 1'b0);
         stepClock();
      end
      applyStimulus(NOP, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      checkOutput("sat_stall_w16", 32'(stall_cnt), 32'd20);
      checkOutput("sat_stall_w4", 32'(s_stall_cnt), 32'd15);
      checkOutput("sat_flush_w4", 32'(s_flush_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
